// File: rtl/pe_core_pkg.sv
// Shared definitions for the residual binary processing element.
//   pe_state_t : controller states (IDLE -> ACC -> BN -> BINZ -> OUT)
//   acc_width  : accumulator width for a given fixed-point width, fold and lane count
//   slice_lo/hi: bit bounds of level `lvl` inside a bus packed as equal-width slices
package pe_core_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC  = 3'd1,
        BN   = 3'd2,
        BINZ = 3'd3,
        OUT  = 3'd4
    } pe_state_t;

    // One sign bit of headroom beyond the worst-case growth over a full pixel.
    function automatic int acc_width(input int tw, input int fold, input int simd);
        return tw + $clog2(fold * simd) + 1;
    endfunction

    function automatic int slice_lo(input int lvl, input int w);
        return lvl * w;
    endfunction

    function automatic int slice_hi(input int lvl, input int w);
        return lvl * w + w - 1;
    endfunction

endpackage

// File: rtl/xnor_popcount.sv
// Combinational SIMD-wide XNOR popcount: number of lanes where a and b agree.
// Ports:
//   a, b : SIMD-bit binary vectors
//   cnt  : count of matching lanes, 0..SIMD
module xnor_popcount #(
    parameter int SIMD = 32,
    parameter int CW   = $clog2(SIMD + 1)
) (
    input  logic [SIMD-1:0] a,
    input  logic [SIMD-1:0] b,
    output logic [CW-1:0]   cnt
);

    logic [SIMD-1:0] eq;

    assign eq = ~(a ^ b);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < SIMD; i++) begin
            cnt = cnt + CW'(eq[i]);
        end
    end

endmodule

// File: rtl/residual_pe_core.sv
// Residual binarised processing element.
// Accumulates FOLD beats of XNOR-popcount products across all input/weight
// residual levels, applies a batch-norm affine step, then re-binarises the
// result greedily into OUT_LEVELS residual sign bits.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : beat handshake (ready only in IDLE and ACC)
//   in_bits, w_bits     : per-level binary activations / weights, level l in slice l
//   in_gamma, w_gamma   : per-level signed fixed-point scales (FRAC fractional bits)
//   bn_alpha, bn_beta   : batch-norm multiplier and offset
//   out_gamma           : non-negative per-level output scales
//   out_valid/out_ready : result handshake; outputs hold steady while waiting
//   out_bits            : output sign bits, 1 = +gamma
//   out_fixed           : reconstructed sum of +/-out_gamma
//   busy                : controller is not in IDLE
//
// Build option: define PE_SAT_EN to saturate acc and r to the signed range of
// their widths; otherwise both wrap in two's complement.
module residual_pe_core
    import pe_core_pkg::*;
#(
    parameter int SIMD       = 32,
    parameter int IN_LEVELS  = 2,
    parameter int W_LEVELS   = 2,
    parameter int OUT_LEVELS = 3,
    parameter int FOLD       = 18,
    parameter int TW         = 24,
    parameter int FRAC       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SIMD*IN_LEVELS-1:0]    in_bits,
    input  logic [SIMD*W_LEVELS-1:0]     w_bits,
    input  logic [TW*IN_LEVELS-1:0]      in_gamma,
    input  logic [TW*W_LEVELS-1:0]       w_gamma,
    input  logic signed [TW-1:0]         bn_alpha,
    input  logic signed [TW-1:0]         bn_beta,
    input  logic [TW*OUT_LEVELS-1:0]     out_gamma,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_LEVELS-1:0]        out_bits,
    output logic signed [TW-1:0]         out_fixed,
    output logic                         busy
);

    localparam int AW  = acc_width(TW, FOLD, SIMD);
    localparam int PCW = $clog2(SIMD + 1);
    localparam int NP  = IN_LEVELS * W_LEVELS;
    // Term-sum width: full gamma product, signed lane count, growth over NP terms.
    localparam int SW  = 2*TW + PCW + 2 + $clog2(NP) + 1;
    localparam int XW  = ((SW > AW) ? SW : AW) + 1;
    localparam int BW  = AW + TW + 1;
    localparam int RW  = TW + 2;
    localparam int BCW = $clog2(FOLD + 1);
    localparam int KW  = $clog2(OUT_LEVELS + 1);

    pe_state_t state, next_state;

    logic signed [AW-1:0] acc;
    logic [BCW-1:0]       beat_cnt;
    logic signed [TW-1:0] r;
    logic [KW-1:0]        k;
    logic                 fire;

    assign fire = in_valid & in_ready;

    // ---------------------------------------------------------------
    // Beat terms: one popcount per (input level, weight level) pair
    // ---------------------------------------------------------------
    logic signed [SW-1:0] term [NP];
    logic signed [SW-1:0] term_sum;

    for (genvar l = 0; l < IN_LEVELS; l++) begin : g_in
        for (genvar w = 0; w < W_LEVELS; w++) begin : g_w
            logic [PCW-1:0]         pc;
            logic signed [PCW+1:0]  cnt_s;
            logic signed [2*TW-1:0] prod;
            logic signed [2*TW-1:0] scale;

            xnor_popcount #(.SIMD(SIMD), .CW(PCW)) u_pc (
                .a   (in_bits[slice_lo(l, SIMD) +: SIMD]),
                .b   (w_bits[slice_lo(w, SIMD) +: SIMD]),
                .cnt (pc)
            );

            // 2*popcount - SIMD: +1 per agreeing lane, -1 per disagreeing lane.
            assign cnt_s = $signed({1'b0, pc, 1'b0}) - $signed((PCW+2)'(SIMD));
            assign prod  = $signed(in_gamma[slice_lo(l, TW) +: TW])
                         * $signed(w_gamma[slice_lo(w, TW) +: TW]);
            assign scale = prod >>> FRAC;
            assign term[l*W_LEVELS + w] = SW'(cnt_s) * SW'(scale);
        end
    end

    always_comb begin
        term_sum = '0;
        for (int p = 0; p < NP; p++) begin
            term_sum = term_sum + term[p];
        end
    end

    // ---------------------------------------------------------------
    // Range fitting: saturate or wrap depending on build option
    // ---------------------------------------------------------------
    function automatic logic signed [AW-1:0] fit_acc(input logic signed [XW-1:0] v);
`ifdef PE_SAT_EN
        logic signed [XW-1:0] hi;
        logic signed [XW-1:0] lo;
        hi = {{(XW-AW+1){1'b0}}, {(AW-1){1'b1}}};
        lo = ~hi;
        if (v > hi)      return hi[AW-1:0];
        else if (v < lo) return lo[AW-1:0];
        else             return v[AW-1:0];
`else
        return v[AW-1:0];
`endif
    endfunction

    function automatic logic signed [TW-1:0] fit_tw(input logic signed [BW-1:0] v);
`ifdef PE_SAT_EN
        logic signed [BW-1:0] hi;
        logic signed [BW-1:0] lo;
        hi = {{(BW-TW+1){1'b0}}, {(TW-1){1'b1}}};
        lo = ~hi;
        if (v > hi)      return hi[TW-1:0];
        else if (v < lo) return lo[TW-1:0];
        else             return v[TW-1:0];
`else
        return v[TW-1:0];
`endif
    endfunction

    // First beat of a pixel loads rather than adds.
    logic signed [XW-1:0] acc_x;
    assign acc_x = (state == IDLE) ? XW'(term_sum) : (XW'(acc) + XW'(term_sum));

    // Batch-norm affine step.
    logic signed [BW-1:0] bn_prod;
    logic signed [BW-1:0] r_bn_x;
    assign bn_prod = BW'(acc) * BW'(bn_alpha);
    assign r_bn_x  = (bn_prod >>> FRAC) + BW'(bn_beta);

    // Greedy residual binarisation, one level per cycle.
    logic [TW-1:0]        g_k;
    logic                 bit_k;
    logic signed [RW-1:0] delta;
    logic signed [BW-1:0] r_bz_x;
    assign g_k    = out_gamma[slice_lo(int'(k), TW) +: TW];
    assign bit_k  = ~r[TW-1];   // r == 0 counts as non-negative
    assign delta  = bit_k ? $signed({2'b00, g_k}) : -$signed({2'b00, g_k});
    assign r_bz_x = BW'(r) - BW'(delta);

    // ---------------------------------------------------------------
    // Controller
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (fire) next_state = (FOLD == 1) ? BN : ACC;
            ACC:     if (fire && beat_cnt == BCW'(FOLD - 1)) next_state = BN;
            BN:      next_state = BINZ;
            BINZ:    if (k == KW'(OUT_LEVELS - 1)) next_state = OUT;
            OUT:     if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = ((state == IDLE) || (state == ACC)) && !rst;
        out_valid = (state == OUT);
        busy      = (state != IDLE);
    end

    // ---------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            beat_cnt  <= '0;
            r         <= '0;
            k         <= '0;
            out_bits  <= '0;
            out_fixed <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fire) begin
                        acc      <= fit_acc(acc_x);
                        beat_cnt <= (FOLD == 1) ? BCW'(0) : BCW'(1);
                    end
                end
                ACC: begin
                    if (fire) begin
                        acc <= fit_acc(acc_x);
                        if (beat_cnt == BCW'(FOLD - 1)) beat_cnt <= '0;
                        else                            beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                BN: begin
                    r         <= fit_tw(r_bn_x);
                    k         <= '0;
                    out_bits  <= '0;
                    out_fixed <= '0;
                end
                BINZ: begin
                    out_bits[k] <= bit_k;
                    r           <= fit_tw(r_bz_x);
                    out_fixed   <= out_fixed + delta[TW-1:0];
                    if (k != KW'(OUT_LEVELS - 1)) k <= k + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_residual_pe_core.sv
module tb_residual_pe_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    endtask

    // ---------------- DUT A: SIMD=32, 1/1/1 levels, FOLD=1 ----------------
    logic              iv_a = 0, ir_a, ov_a, busy_a;
    logic              or_a = 1;
    logic [31:0]       ib_a = 0, wb_a = 0;
    logic [23:0]       ig_a = 24'd256, wg_a = 24'd256, og_a = 24'd256;
    logic signed [23:0] al_a = 24'sd256, be_a = 0, fx_a;
    logic [0:0]        ob_a;

    residual_pe_core #(.SIMD(32), .IN_LEVELS(1), .W_LEVELS(1), .OUT_LEVELS(1),
                       .FOLD(1), .TW(24), .FRAC(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a),
        .in_bits(ib_a), .w_bits(wb_a), .in_gamma(ig_a), .w_gamma(wg_a),
        .bn_alpha(al_a), .bn_beta(be_a), .out_gamma(og_a),
        .out_valid(ov_a), .out_ready(or_a), .out_bits(ob_a),
        .out_fixed(fx_a), .busy(busy_a));

    // ---------------- DUT B: default parameters ----------------
    logic              iv_b = 0, ir_b, ov_b, busy_b;
    logic              or_b = 0;
    logic [63:0]       ib_b = 0, wb_b = 0;
    logic [47:0]       ig_b = {24'd0, 24'd256}, wg_b = {24'd0, 24'd256};
    logic [71:0]       og_b = {24'd64, 24'd128, 24'd256};
    logic signed [23:0] al_b = 24'sd256, be_b = 0, fx_b;
    logic [2:0]        ob_b;

    residual_pe_core dut_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b),
        .in_bits(ib_b), .w_bits(wb_b), .in_gamma(ig_b), .w_gamma(wg_b),
        .bn_alpha(al_b), .bn_beta(be_b), .out_gamma(og_b),
        .out_valid(ov_b), .out_ready(or_b), .out_bits(ob_b),
        .out_fixed(fx_b), .busy(busy_b));

    // ---------------- DUT C: tiny widths for overflow behaviour ----------------
    logic              iv_c = 0, ir_c, ov_c, busy_c;
    logic              or_c = 1;
    logic [3:0]        ib_c = 0, wb_c = 0;
    logic [7:0]        ig_c = 0, wg_c = 0, og_c = 8'd1;
    logic signed [7:0] al_c = 8'sd1, be_c = 0, fx_c;
    logic [0:0]        ob_c;
    logic signed [11:0] acc_c;

    residual_pe_core #(.SIMD(4), .IN_LEVELS(1), .W_LEVELS(1), .OUT_LEVELS(1),
                       .FOLD(2), .TW(8), .FRAC(0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(ir_c),
        .in_bits(ib_c), .w_bits(wb_c), .in_gamma(ig_c), .w_gamma(wg_c),
        .bn_alpha(al_c), .bn_beta(be_c), .out_gamma(og_c),
        .out_valid(ov_c), .out_ready(or_c), .out_bits(ob_c),
        .out_fixed(fx_c), .busy(busy_c));

    assign acc_c = dut_c.acc;

    // ---------------- Vector table for DUT A ----------------
    typedef struct {
        logic [31:0]        ib;
        logic [31:0]        wb;
        logic signed [23:0] alpha;
        logic signed [23:0] beta;
        logic [23:0]        og;
        logic               eb;
        int                 efix;
    } vec_t;

    vec_t va[6];

    // Feed nb beats to DUT B; level-0 activations either match or oppose the weights.
    task automatic b_beats(input int nb, input bit mis, input bit gaps);
        logic [31:0] w0;
        w0 = 32'h1234_5678;
        for (int b = 0; b < nb; b++) begin
            if (gaps) begin
                iv_b = 1'b0;
                @(posedge clk); @(negedge clk);
            end
            wb_b = {32'hDEAD_BEEF, w0};
            ib_b = {$urandom, mis ? ~w0 : w0};
            iv_b = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        iv_b = 1'b0;
    endtask

    task automatic wait_ov_b(output int n);
        n = 0;
        while (!ov_b && n < 60) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int any_ov;
        int e1, e2;

        //           ib            wb            alpha  beta    og    eb  efix
        va[0] = '{32'h0000_0000, 32'h0000_0000, 256,   0,      256,  1,  256};  // all equal
        va[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 256,   0,      256,  0, -256};  // r = -8192
        va[2] = '{32'hFFFF_0000, 32'h0000_0000, 256,   0,      256,  1,  256};  // r == 0
        va[3] = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 256,  -8193,   100,  0, -100};  // r = -1
        va[4] = '{32'h0F0F_0F0F, 32'h0F0F_0F0F, 128,   0,      512,  1,  512};  // alpha 0.5
        va[5] = '{32'h0000_00FF, 32'h0000_0000, 256,  -4096,   7,    1,  7};    // 24 matches, r = 0

        // ---------- reset state ----------
        repeat (3) @(negedge clk);
        check("rst_b_valid", ov_b, 0);
        check("rst_b_busy", busy_b, 0);
        check("rst_b_bits", ob_b, 0);
        check("rst_b_fixed", fx_b, 0);
        check("rst_a_fixed", fx_a, 0);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rst_b_in_ready", ir_b, 1);
        check("rst_a_in_ready", ir_a, 1);

        // ---------- DUT A table ----------
        for (int i = 0; i < 6; i++) begin
            ib_a = va[i].ib; wb_a = va[i].wb;
            al_a = va[i].alpha; be_a = va[i].beta; og_a = va[i].og;
            iv_a = 1'b1;
            @(posedge clk); @(negedge clk);
            iv_a = 1'b0;
            n = 0;
            while (!ov_a && n < 20) begin
                @(posedge clk); @(negedge clk);
                n++;
            end
            check($sformatf("a%0d_valid", i), ov_a, 1);
            check($sformatf("a%0d_latency", i), n, 2);
            check($sformatf("a%0d_bits", i), ob_a, va[i].eb);
            check($sformatf("a%0d_fixed", i), fx_a, va[i].efix);
            @(posedge clk); @(negedge clk);
            check($sformatf("a%0d_idle", i), busy_a, 0);
        end

        // ---------- DUT B: gapped pixel, r = 300 ----------
        be_b = -24'sd147156;
        b_beats(18, 1'b0, 1'b1);
        check("b1_busy", busy_b, 1);
        check("b1_early_valid", ov_b, 0);
        wait_ov_b(n);
        check("b1_valid", ov_b, 1);
        check("b1_latency", n, 4);
        check("b1_bits", ob_b, 3'b011);
        check("b1_fixed", fx_b, 320);

        // Output held while the consumer stalls.
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("b1_hold%0d_valid", c), ov_b, 1);
            check($sformatf("b1_hold%0d_bits", c), ob_b, 3'b011);
            check($sformatf("b1_hold%0d_fixed", c), fx_b, 320);
            check($sformatf("b1_hold%0d_in_ready", c), ir_b, 0);
        end
        or_b = 1'b1;
        @(posedge clk); @(negedge clk);
        or_b = 1'b0;
        check("b1_drain_valid", ov_b, 0);
        check("b1_drain_in_ready", ir_b, 1);
        check("b1_drain_busy", busy_b, 0);

        // ---------- DUT B: reset mid-pixel, then a fresh pixel ----------
        be_b = 24'sd147356;
        b_beats(7, 1'b1, 1'b0);
        check("b2_busy_before_rst", busy_b, 1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("b2_rst_busy", busy_b, 0);
        rst = 1'b0;
        @(negedge clk);
        check("b2_rst_in_ready", ir_b, 1);
        any_ov = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); @(negedge clk);
            if (ov_b) any_ov = 1;
        end
        check("b2_no_stale_valid", any_ov, 0);

        b_beats(18, 1'b1, 1'b0);
        wait_ov_b(n);
        check("b3_valid", ov_b, 1);
        check("b3_latency", n, 4);
        check("b3_bits", ob_b, 3'b110);
        check("b3_fixed", fx_b, -64);
        or_b = 1'b1;
        @(posedge clk); @(negedge clk);
        or_b = 1'b0;
        check("b3_idle", busy_b, 0);

        // ---------- DUT C: beats that overflow the accumulator ----------
        ig_c = 8'd127; wg_c = 8'd127; ib_c = 4'hF; wb_c = 4'hF;
`ifdef PE_SAT_EN
        e1 = 2047; e2 = 2047;
`else
        e1 = -1020; e2 = -2040;
`endif
        iv_c = 1'b1;
        @(posedge clk); @(negedge clk);
        check("c_acc_beat1", acc_c, e1);
        @(posedge clk); @(negedge clk);
        iv_c = 1'b0;
        check("c_acc_beat2", acc_c, e2);
        n = 0;
        while (busy_c && n < 20) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        check("c_idle", busy_c, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/residual_pe_core.md
RESIDUAL_PE_CORE -- requirements
Module: residual_pe_core

Interface
REQ-001 SHALL have parameter SIMD, default 32, meaning binary lanes per beat.
REQ-002 SHALL have parameter IN_LEVELS, default 2, meaning residual input levels.
REQ-003 SHALL have parameter W_LEVELS, default 2, meaning residual weight levels.
REQ-004 SHALL have parameter OUT_LEVELS, default 3, meaning residual output levels.
REQ-005 SHALL have parameter FOLD, default 18, meaning beats per output pixel.
REQ-006 SHALL have parameter TW, default 24, meaning signed fixed-point width.
REQ-007 SHALL have parameter FRAC, default 8, meaning fractional bits.
REQ-008 SHALL have port clk, input, 1, meaning the single clock.
REQ-009 SHALL have port rst, input, 1, meaning reset; asynchronous, active-high.
REQ-010 SHALL have port in_valid, input, 1, meaning the beat is valid.
REQ-011 SHALL have port in_ready, output, 1, meaning a beat is accepted.
REQ-012 SHALL have port in_bits, input, SIMD*IN_LEVELS, meaning input level l in slice l.
REQ-013 SHALL have port w_bits, input, SIMD*W_LEVELS, meaning weight level w in slice w.
REQ-014 SHALL have port in_gamma, input, TW*IN_LEVELS, meaning per-level input scales.
REQ-015 SHALL have port w_gamma, input, TW*W_LEVELS, meaning per-level weight scales.
REQ-016 SHALL have port bn_alpha, input, TW, meaning the BN multiplier.
REQ-017 SHALL have port bn_beta, input, TW, meaning the BN offset.
REQ-018 SHALL have port out_gamma, input, TW*OUT_LEVELS, meaning non-negative output scales.
REQ-019 SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-020 SHALL have port out_ready, input, 1, meaning the consumer accepts.
REQ-021 SHALL have port out_bits, output, OUT_LEVELS, meaning output sign bits; 1 = +gamma.
REQ-022 SHALL have port out_fixed, output, TW, meaning the reconstructed sum of ±out_gamma.
REQ-023 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-024 SHALL define beat term(l,w) = (2*popcount(XNOR(in_l,w_w)) - SIMD) * ((in_gamma[l]*w_gamma[w]) >>> FRAC).
REQ-025 SHALL add the sum of all IN_LEVELS*W_LEVELS terms to acc on each accepted beat (in_valid & in_ready).
REQ-026 SHALL hold acc in TW+$clog2(FOLD*SIMD)+1 bits.
REQ-027 SHALL use FSM states IDLE, ACC, BN, BINZ, OUT.
REQ-028 SHALL, in IDLE, assert in_ready; the first accepted beat loads acc with its term sum (not added), sets beat_cnt=1, and goes to ACC.
REQ-029 SHALL, in ACC, assert in_ready and add beats; after the beat making beat_cnt==FOLD, go to BN and clear beat_cnt.
REQ-030 SHALL keep in_ready low in BN, BINZ and OUT.
REQ-031 SHALL, in BN, compute r = ((acc*bn_alpha) >>> FRAC) + bn_beta, truncated to TW, in one cycle, then go to BINZ.
REQ-032 SHALL, in BINZ, handle one level per cycle for k = 0..OUT_LEVELS-1: bit[k] = (r >= 0); r -= bit ? g[k] : -g[k]; recon += bit ? g[k] : -g[k].
REQ-033 SHALL go from BINZ to OUT after level OUT_LEVELS-1.
REQ-034 SHALL hold out_valid=1 and stable outputs in OUT until out_ready, then return to IDLE.
REQ-035 SHALL give a latency of FOLD accepted beats + 1 (BN) + OUT_LEVELS (BINZ) cycles to out_valid.
REQ-036 SHALL treat an r of exactly 0 as bit 1.
REQ-037 SHALL treat FOLD=1 as IDLE going directly to BN.
REQ-038 SHALL leave acc and beat_cnt unchanged on gaps (in_valid low).
REQ-039 SHALL, on asserting rst mid-pixel, discard the partial pixel.

Reset
REQ-040 SHALL, on rst, clear state to IDLE and set acc, beat_cnt, r, out_bits, out_fixed, out_valid and busy to 0.
REQ-041 SHALL, on rst, set in_ready to 1 (the IDLE value) once rst deasserts.

Configuration
REQ-042 SHALL saturate acc and r to the signed range of their width when PE_SAT_EN is defined.
REQ-043 SHALL, without PE_SAT_EN, let both wrap in two's complement.

Structure
REQ-044 SHALL place the FSM state enum, the acc-width function and the level-slice helpers in package pe_core_pkg.
REQ-045 SHALL implement the combinational SIMD-wide XNOR-popcount as sub-module xnor_popcount, instantiated IN_LEVELS*W_LEVELS times.

Verification
REQ-046 SHALL test SIMD=32, FOLD=1, 1/1/1 levels, gammas=1.0 (256), alpha=1.0, beta=0, with all-equal bits -> out_bits=1 and out_fixed=+256.
REQ-047 SHALL test the same setup with in_bits=~w_bits and beta=0 -> r=-8192 and out_bits=0.
REQ-048 SHALL test FOLD=18 with in_valid toggling every other cycle -> out_valid exactly after the 18th accepted beat + 1 + OUT_LEVELS cycles.
REQ-049 SHALL test OUT_LEVELS=3, out_gamma={256,128,64}, r=300 -> out_bits=1,1,0 (k=0..2) and out_fixed=320.
REQ-050 SHALL test out_ready held low for 5 cycles -> outputs stable and in_ready low; accept -> IDLE with in_ready=1.
REQ-051 SHALL test rst asserted at beat 7 of 18 -> out_valid never rises, and the next pixel result matches a fresh-run model.
REQ-052 SHALL test, with PE_SAT_EN, forced maximal positive beats beyond range -> acc pinned at max; without it -> wraps.
